sram_rw_arbiter: RTL and testbench

- Controller that owns the single RW port of one 15x4096 single-port SRAM array macro wrapper.
- After reset it zero-fills the whole array with a sequential sweep.
- It then shares the port between one write requester and one read requester using valid/ready handshakes and round-robin on conflict.
- It returns read data with fixed latency, and it sits directly in front of the array wrapper inside a predictor/table block.

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_rw_arbiter_rr_arb2.sv | 47 ++++
 rtl/sram_rw_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_rw_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for single-port SRAM controllers.
// Contents: default address/data widths, controller state and
// round-robin priority enums.
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W_DFLT = 12;
    localparam int unsigned DATA_W_DFLT = 15;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_ctrl_state_e;

    typedef enum logic [0:0] {
        WRITE = 1'b0,
        READ  = 1'b1
    } rr_prio_e;

endpackage

// File: rtl/sram_rw_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter (write side vs read side) with
// combinational valid/ready grants and a registered priority pointer.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en_i                arbitration enabled (no ready/grant when low)
//   w_req_i, r_req_i    request valids
//   w_ready_c_o/r_ready_c_o  combinational readies
//   w_gnt_c_o/r_gnt_c_o      combinational grants (valid & ready)
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic w_req_i,
    input  logic r_req_i,
    output logic w_ready_c_o,
    output logic r_ready_c_o,
    output logic w_gnt_c_o,
    output logic r_gnt_c_o
);

    rr_prio_e prio_q;
    rr_prio_e prio_d;

    // A side is ready unless the other side is contending and holds priority.
    always_comb begin
        w_ready_c_o = en_i & (~r_req_i | (prio_q == WRITE));
        r_ready_c_o = en_i & (~w_req_i | (prio_q == READ));
        w_gnt_c_o   = w_req_i & w_ready_c_o;
        r_gnt_c_o   = r_req_i & r_ready_c_o;
        prio_d      = prio_q;
        // Pointer only moves when a real conflict was resolved.
        if (w_req_i && r_req_i && (w_gnt_c_o || r_gnt_c_o)) begin
            prio_d = (prio_q == WRITE) ? READ : WRITE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= WRITE;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: owns the single RW port of a single-port SRAM wrapper.
// Zero-fills the array after reset (and on init_start), then shares the port
// between one write and one read requester with round-robin on conflict.
// Read data returns one cycle after the read grant.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   init_start                     restart the zero-fill (RUN only)
//   busy                           sweep in progress
//   w_valid/w_ready/w_addr/w_data  write request channel
//   r_valid/r_ready/r_addr         read request channel
//   resp_valid/resp_data           read response (no backpressure)
//   RW0_*                          array macro port
module sram_rw_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DFLT,
    parameter int unsigned DATA_W  = DATA_W_DFLT,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              init_start,
    output logic              busy,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_clk,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    sram_ctrl_state_e  state_q;
    sram_ctrl_state_e  state_d;
    logic [ADDR_W-1:0] sweep_q;
    logic [ADDR_W-1:0] sweep_d;
    logic              resp_valid_q;
    logic              arb_en;
    logic              w_gnt;
    logic              r_gnt;

    assign RW0_clk = clock;

    rr_arb2 u_arb (
        .clk         (clock),
        .rst_n       (reset_n),
        .en_i        (arb_en),
        .w_req_i     (w_valid),
        .r_req_i     (r_valid),
        .w_ready_c_o (w_ready),
        .r_ready_c_o (r_ready),
        .w_gnt_c_o   (w_gnt),
        .r_gnt_c_o   (r_gnt)
    );

    // Next state, sweep counter and array port drive.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        arb_en    = 1'b0;
        busy      = 1'b0;
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wdata = '0;

        unique case (state_q)
            INIT: begin
                busy      = 1'b1;
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = sweep_q;
                // Counter wraps to zero on the last address, ready for the next sweep.
                sweep_d   = sweep_q + ADDR_W'(1);
                if (sweep_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                arb_en = 1'b1;
                if (w_gnt) begin
                    RW0_en    = 1'b1;
                    RW0_wmode = 1'b1;
                    RW0_addr  = w_addr;
                    RW0_wdata = w_data;
                end else if (r_gnt) begin
                    RW0_en    = 1'b1;
                    RW0_addr  = r_addr;
                end
                // The grant of this cycle still completes before the sweep starts.
                if (INIT_EN && init_start) begin
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if (INIT_EN) begin
                state_q <= INIT;
            end else begin
                state_q <= RUN;
            end
            sweep_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            resp_valid_q <= r_gnt;
        end
    end

    // Array read data is valid the cycle after the enable; pass it straight through.
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_valid_q ? RW0_rdata : '0;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Self-checking bench for sram_rw_arbiter: array model, cycle-level reference
// model of the arbitration rules, response scoreboard and a directed plus
// randomized stimulus sequence.
module tb_sram_rw_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 15;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock      = 1'b0;
    logic          reset_n    = 1'b0;
    logic          init_start = 1'b0;
    logic          busy;
    logic          w_valid    = 1'b0;
    logic          w_ready;
    logic [AW-1:0] w_addr     = '0;
    logic [DW-1:0] w_data     = '0;
    logic          r_valid    = 1'b0;
    logic          r_ready;
    logic [AW-1:0] r_addr     = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] RW0_addr;
    logic          RW0_en;
    logic          RW0_clk;
    logic          RW0_wmode;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] RW0_rdata;

    always #5 clock = ~clock;

    sram_rw_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .INIT_EN (1'b1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .init_start (init_start),
        .busy       (busy),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_addr     (r_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .RW0_addr   (RW0_addr),
        .RW0_en     (RW0_en),
        .RW0_clk    (RW0_clk),
        .RW0_wmode  (RW0_wmode),
        .RW0_wdata  (RW0_wdata),
        .RW0_rdata  (RW0_rdata)
    );

    // Single-port array macro model, clocked from the controller's RW0_clk.
    logic [DW-1:0] arr [DEPTH];
    always @(posedge RW0_clk) begin
        if (RW0_en) begin
            if (RW0_wmode) arr[RW0_addr] <= RW0_wdata;
            else           RW0_rdata     <= arr[RW0_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_init   = 1'b1;
    int            m_sweep  = 0;
    bit            prio_w   = 1'b1;
    int            cyc      = 0;
    int            resp_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Per-cycle model: sweep pins, grant rules, array port, and expected responses.
    always @(negedge clock) begin
        bit exp_wr;
        bit exp_rr;
        if (!reset_n) begin
            m_init  = 1'b1;
            m_sweep = 0;
            prio_w  = 1'b1;
            exp_q.delete();
            chk("rst_busy",       32'(busy),       1);
            chk("rst_w_ready",    32'(w_ready),    0);
            chk("rst_r_ready",    32'(r_ready),    0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_data",  32'(resp_data),  0);
        end else if (m_init) begin
            chk("sweep_busy",    32'(busy),      1);
            chk("sweep_w_ready", 32'(w_ready),   0);
            chk("sweep_r_ready", 32'(r_ready),   0);
            chk("sweep_en",      32'(RW0_en),    1);
            chk("sweep_wmode",   32'(RW0_wmode), 1);
            chk("sweep_addr",    32'(RW0_addr),  32'(m_sweep));
            chk("sweep_wdata",   32'(RW0_wdata), 0);
            m_sweep++;
            if (m_sweep == int'(DEPTH)) begin
                m_init  = 1'b0;
                m_sweep = 0;
                for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
            end
        end else begin
            // On conflict the side that did not win the previous conflict wins.
            exp_wr = !r_valid || prio_w;
            exp_rr = !w_valid || !prio_w;
            chk("run_busy",    32'(busy),    0);
            chk("run_w_ready", 32'(w_ready), 32'(exp_wr));
            chk("run_r_ready", 32'(r_ready), 32'(exp_rr));
            if (w_valid && exp_wr) begin
                chk("wr_en",    32'(RW0_en),    1);
                chk("wr_wmode", 32'(RW0_wmode), 1);
                chk("wr_addr",  32'(RW0_addr),  32'(w_addr));
                chk("wr_wdata", 32'(RW0_wdata), 32'(w_data));
                ref_mem[w_addr] = w_data;
            end else if (r_valid && exp_rr) begin
                chk("rd_en",    32'(RW0_en),    1);
                chk("rd_wmode", 32'(RW0_wmode), 0);
                chk("rd_addr",  32'(RW0_addr),  32'(r_addr));
                chk("rd_wdata", 32'(RW0_wdata), 0);
                exp_q.push_back('{data: ref_mem[r_addr], cyc: cyc});
            end else begin
                chk("idle_en",    32'(RW0_en),    0);
                chk("idle_wmode", 32'(RW0_wmode), 0);
                chk("idle_addr",  32'(RW0_addr),  0);
                chk("idle_wdata", 32'(RW0_wdata), 0);
            end
            if (w_valid && r_valid) prio_w = !prio_w;
            if (init_start) begin
                m_init  = 1'b1;
                m_sweep = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents data.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (resp_valid) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data",    32'(resp_data), 32'(e.data));
                    chk("resp_latency", 32'(cyc),       32'(e.cyc + 1));
                end
            end else begin
                chk("resp_data_idle", 32'(resp_data), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        forever begin
            @(negedge clock);
            if (!busy) break;
            guard++;
            if (guard > 6000) begin
                chk("wait_idle_timeout", 32'(busy), 0);
                break;
            end
        end
        tick();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int guard = 0;
        w_valid = 1'b1;
        w_addr  = a;
        w_data  = d;
        forever begin
            @(negedge clock);
            if (w_ready) break;
            guard++;
            if (guard > 50) begin
                chk("write_timeout", 32'(w_ready), 1);
                break;
            end
        end
        tick();
        w_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        int guard = 0;
        r_valid = 1'b1;
        r_addr  = a;
        forever begin
            @(negedge clock);
            if (r_ready) break;
            guard++;
            if (guard > 50) begin
                chk("read_timeout", 32'(r_ready), 1);
                break;
            end
        end
        tick();
        r_valid = 1'b0;
    endtask

    initial begin
        int  n0;
        int  guard;
        bit  w_acc;
        bit  r_acc;
        logic [AW-1:0] tmp_a;

        // Array powers up with garbage so the zero-fill is observable.
        for (int i = 0; i < int'(DEPTH); i++) arr[i] = DW'($urandom);
        RW0_rdata = DW'($urandom);

        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_idle();

        // Swept array reads back zero at both ends and the middle.
        do_read(AW'(0));
        do_read(AW'(2048));
        do_read(AW'(4095));

        // Read-after-write in consecutive cycles.
        do_write(AW'(12'h123), DW'(16'h5A5A));
        do_read(AW'(12'h123));
        tick();

        // Sustained conflict: W,R,W,R,W,R and three responses.
        n0      = resp_cnt;
        w_valid = 1'b1;
        w_addr  = AW'(40);
        w_data  = DW'(15'h0ABC);
        r_valid = 1'b1;
        r_addr  = AW'(40);
        repeat (6) tick();
        w_valid = 1'b0;
        r_valid = 1'b0;
        repeat (2) tick();
        chk("conflict_resp_count", 32'(resp_cnt - n0), 3);

        // Back-to-back reads of 1,2,3.
        do_write(AW'(1), DW'(15'h0111));
        do_write(AW'(2), DW'(15'h0222));
        do_write(AW'(3), DW'(15'h0333));
        n0 = resp_cnt;
        r_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            r_addr = AW'(i);
            tick();
        end
        r_valid = 1'b0;
        repeat (2) tick();
        chk("stream_resp_count", 32'(resp_cnt - n0), 3);

        // Randomized traffic over a small address window; payloads held until accepted.
        w_acc = 1'b0;
        r_acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!w_valid || w_acc) begin
                w_valid = 1'($urandom_range(0, 1));
                w_addr  = AW'($urandom_range(0, 15));
                w_data  = DW'($urandom);
            end
            if (!r_valid || r_acc) begin
                r_valid = 1'($urandom_range(0, 1));
                r_addr  = AW'($urandom_range(0, 15));
            end
            @(negedge clock);
            w_acc = w_valid && w_ready;
            r_acc = r_valid && r_ready;
            tick();
        end
        w_valid = 1'b0;
        r_valid = 1'b0;
        repeat (2) tick();

        // init_start together with a read grant: response still delivered, then re-sweep.
        do_write(AW'(5), DW'(15'h7FFF));
        r_valid    = 1'b1;
        r_addr     = AW'(5);
        init_start = 1'b1;
        @(negedge clock);
        chk("init_rd_ready", 32'(r_ready), 1);
        tick();
        r_valid    = 1'b0;
        init_start = 1'b0;
        // init_start mid-sweep must not restart it.
        repeat (500) tick();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        wait_idle();
        do_read(AW'(5));
        tick();

        // Reset asserted mid-sweep at address 1000.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        guard = 0;
        forever begin
            @(negedge clock);
            tmp_a = RW0_addr;
            if (tmp_a == AW'(1000)) break;
            guard++;
            if (guard > 2000) begin
                chk("sweep_1000_timeout", 32'(tmp_a), 1000);
                break;
            end
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_addr", 32'(RW0_addr), 0);
        chk("async_rst_busy", 32'(busy),     1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_idle();

        // Reset asserted while a response is on the bus drops it immediately.
        do_write(AW'(7), DW'(15'h1234));
        r_valid = 1'b1;
        r_addr  = AW'(7);
        @(negedge clock);
        tick();
        r_valid = 1'b0;
        chk("resp_before_rst", 32'(resp_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_resp_valid", 32'(resp_valid), 0);
        chk("async_rst_resp_data",  32'(resp_data),  0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_idle();
        do_read(AW'(7));
        repeat (3) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
